// File: rtl/adc_psram_pkg.sv
// rtl/adc_psram_pkg.sv - shared types and constants for the ADC-to-PSRAM writer
package adc_psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int SLOT_W         = 16;
    localparam int SLOTS_PER_WORD = 4;
    localparam int WORD_W         = SLOT_W * SLOTS_PER_WORD;

    // Oldest sample of a word sits in the least-significant slot.
    localparam bit PACK_OLDEST_LSB = 1'b1;

    function automatic logic [1:0] slot_pos(input logic [1:0] idx);
        return PACK_OLDEST_LSB ? idx : (2'(SLOTS_PER_WORD - 1) - idx);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-based synchronous FIFO with extra-bit full/empty tracking
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !clear) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/adc_psram_writer.sv
// rtl/adc_psram_writer.sv - packs 12-bit ADC samples four per 64-bit word and streams them to PSRAM
module adc_psram_writer
    import adc_psram_pkg::*;
#(
    parameter int ADC_BITS   = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 21,
    parameter int ADDR_STEP  = 4,
    parameter int CNT_W      = 18
) (
    input  logic                clk_PSRAM,
    input  logic                rst_n,
    input  logic [ADC_BITS-1:0] adc_data,
    input  logic                data_available,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    num_samples,
    output logic                mem_wr_valid,
    input  logic                mem_wr_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [63:0]         mem_data,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_num;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_idx;
    logic [WORD_W-1:0]   r_word;
    logic                r_push;
    logic                r_overflow;

    logic                w_start_ok;
    logic                w_take;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [WORD_W-1:0]   w_head;

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_take     = (r_state == ST_CAPTURE) && data_available && (r_cnt != r_num);
    assign w_pop      = mem_wr_valid && mem_wr_ready;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_PSRAM),
        .rst_n (rst_n),
        .clear (w_start_ok),
        .push  (r_push),
        .din   (r_word),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_next_state = (num_samples == '0) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (r_cnt == r_num) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_empty && !r_push) w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
        done         = (r_state == ST_DONE);
        mem_wr_valid = busy && !w_empty;
        mem_addr     = r_addr;
        mem_data     = w_head;
        overflow     = r_overflow;
    end

    // The completed word is pushed one edge after its fourth sample lands.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_num      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_push     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_start_ok) begin
                r_addr     <= base_addr;
                r_num      <= num_samples;
                r_cnt      <= '0;
                r_idx      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_take) begin
                    r_word[slot_pos(r_idx)*SLOT_W +: SLOT_W] <=
                        {{(SLOT_W-ADC_BITS){1'b0}}, adc_data};
                    r_idx  <= r_idx + 2'd1;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_push <= (r_idx == 2'd3);
                end
                if (w_pop) r_addr <= r_addr + ADDR_W'(ADDR_STEP);
                if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/adc_psram_writer.md
Name: adc_psram_writer

Overview:
Downstream consumer of the ADC capture submodule. Takes 12-bit samples qualified by a one-cycle data_available strobe. Packs four samples into one 64-bit word and buffers the words in a small FIFO. Drains the FIFO to the PSRAM controller write port as sequential-address word writes until a programmed sample count is reached.

Parameters:
ADC_BITS, 12, sample width; each sample is zero-extended to a 16-bit slot
FIFO_DEPTH, 8, 64-bit words buffered; power of two, at least 2
ADDR_W, 21, PSRAM word-address width
ADDR_STEP, 4, address increment per 64-bit word, in 16-bit units
CNT_W, 18, width of the sample-count register

Ports:
clk_PSRAM  in  1  single clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
adc_data  in  ADC_BITS  sample from the ADC submodule; valid only while data_available=1
data_available  in  1  one-cycle sample strobe
start  in  1  pulse; arms a capture, ignored unless state is IDLE or DONE
base_addr  in  ADDR_W  first PSRAM address; sampled when start is accepted
num_samples  in  CNT_W  samples to store; sampled at start; must be a multiple of 4 and nonzero
mem_wr_valid  out  1  write request to the PSRAM controller
mem_wr_ready  in  1  controller accepts a request when valid&&ready
mem_addr  out  ADDR_W  word address of the current request
mem_data  out  64  packed data; sample k occupies bits [16k+15:16k], k=0 is oldest
busy  out  1  high in CAPTURE or DRAIN
done  out  1  high in DONE until the next accepted start
overflow  out  1  sticky; set when a packed word is dropped because the FIFO is full

Behaviour:
- Reset: state=IDLE. All outputs are 0: mem_wr_valid, mem_addr, mem_data, busy, done, overflow. FIFO empty, pack slot index 0, counters 0.
- Reset mid-operation has the same effect; the partial word and FIFO contents are discarded.
- States and transitions:
  - IDLE → CAPTURE on start.
  - CAPTURE → DRAIN when the sample counter reaches num_samples.
  - DRAIN → DONE when the FIFO is empty and no request is outstanding.
  - DONE → CAPTURE on start.
- start accepted: latch base_addr and num_samples, clear the sample counter, slot index, FIFO and overflow, set busy. If num_samples==0, go directly to DONE on the next cycle.
- Packing, in CAPTURE only, on each data_available:
  - Write {4'b0, adc_data} into slot[idx], increment idx and the sample counter.
  - When idx wraps 3→0, push the 4-slot word into the FIFO on the next edge; latency is 1 cycle.
  - data_available is ignored outside CAPTURE and after the count is reached.
- FIFO full at push: the word is dropped, overflow is set, and the sample counter still advances, so the capture length stays fixed. Full and empty are tracked with an extra pointer bit.
- A simultaneous push and pop while full: the pop frees the slot, so the push succeeds.
- Write port: mem_wr_valid=1 whenever the FIFO is non-empty and state is CAPTURE or DRAIN.
  - mem_data is the FIFO head. mem_addr = base_addr + ADDR_STEP*words_accepted.
  - mem_data and mem_addr stay stable while valid && !ready.
  - Pop and address increment happen on the valid&&ready edge.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Register-output FIFO: a pushed word can be presented at the earliest 1 cycle after the push.
- done asserts on the cycle DONE is entered. busy deasserts on the same cycle.

Decomposition:
- Shared package adc_psram_pkg holds: state enum (IDLE, CAPTURE, DRAIN, DONE), SLOT_W=16, SLOTS_PER_WORD=4, and the packing-order constant.
- One sub-module: sync_fifo, with parameters width and depth, ports push/pop/full/empty, register-based storage. It is reused later for the readback path.

Test Plan:
- Basic capture: base_addr=0x100, num_samples=8, samples 0x001..0x008, ready tied to 1 → two writes.
  - addr 0x100, data 0x0004_0003_0002_0001.
  - addr 0x104, data 0x0008_0007_0006_0005.
  - done=1, overflow=0.
- Backpressure: ready=0 for 20 cycles during a 16-sample capture → mem_addr and mem_data held stable while valid; all 4 words later delivered in order; overflow=0.
- Overflow: FIFO_DEPTH=8, ready held 0, 40 samples → 8 words buffered, words 9–10 dropped, overflow=1. After ready=1: exactly 8 writes, then DONE.
- Ignored strobes and zero length:
  - data_available pulses while IDLE → no writes.
  - start with num_samples=0 → done=1 one cycle later, no writes.
- Reset mid-capture: assert rst_n=0 after 6 samples → all outputs 0, state IDLE. A new start at base 0x200 with 4 samples → one write at 0x200 holding only the new samples.
- Address wrap: base_addr=2^21−4, 8 samples → writes at 0x1FFFFC then 0x000000.
